aux_req_router: RTL and testbench

Parametrised, registered request router for the AUX request path. It takes one controller request stream (cmd/data/address/len with valid/ready) plus a channel select, and buffers each request into one of NUM_CH per-channel FIFOs. Each channel has its own valid/ready output toward its transaction engine (channel 0 native, channel 1 I2C-over-AUX by default). It replaces the purely combinational native/I2C split with backpressure, buffering, N-way routing and misroute detection.

---
 rtl/aux_router_pkg.sv | 21 ++
 rtl/aux_req_fifo.sv | 49 ++++
 rtl/aux_req_router.sv | 82 ++++++++
 tb/tb_aux_req_router.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/aux_router_pkg.sv
// aux_router_pkg: default request field widths, the request struct and the
// channel-index width helper shared by the AUX request router.
package aux_router_pkg;

    localparam int DEF_CMD_W  = 2;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 20;
    localparam int DEF_LEN_W  = 8;

    typedef struct packed {
        logic [DEF_CMD_W-1:0]  cmd;
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_ADDR_W-1:0] address;
        logic [DEF_LEN_W-1:0]  len;
    } req_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aux_req_fifo.sv
// aux_req_fifo: synchronous FIFO of request structs with occupancy level.
// Push while full and pop while empty are ignored.
module aux_req_fifo
    import aux_router_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = req_t,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  T                 wdata,
    input  logic             pop,
    output T                 rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    T           mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic       do_push, do_pop;

    assign full    = level == CNT_W'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            level  <= level + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= wdata;

endmodule

// File: rtl/aux_req_router.sv
// aux_req_router: routes one AUX request stream into NUM_CH buffered channels,
// sinking and flagging requests whose channel select is out of range.
module aux_req_router
    import aux_router_pkg::*;
#(
    parameter int                NUM_CH     = 2,
    parameter int                DEPTH      = 2,
    parameter int                CMD_W      = DEF_CMD_W,
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                LEN_W      = DEF_LEN_W,
    parameter logic [NUM_CH-1:0] CH_DATA_EN = NUM_CH'(1),
    localparam int               CH_W       = ch_width(NUM_CH),
    localparam int               CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CMD_W-1:0]           in_cmd,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [ADDR_W-1:0]          in_address,
    input  logic [LEN_W-1:0]           in_len,
    input  logic [CH_W-1:0]            in_ch_sel,
    input  logic                       in_tr_vld,
    output logic                       in_tr_rdy,
    output logic [NUM_CH*CMD_W-1:0]    out_cmd,
    output logic [NUM_CH*DATA_W-1:0]   out_data,
    output logic [NUM_CH*ADDR_W-1:0]   out_address,
    output logic [NUM_CH*LEN_W-1:0]    out_len,
    output logic [NUM_CH-1:0]          out_tr_vld,
    input  logic [NUM_CH-1:0]          out_tr_rdy,
    output logic [NUM_CH*CNT_W-1:0]    ch_level,
    output logic                       route_err
);

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] address;
        logic [LEN_W-1:0]  len;
    } req_w_t;

    logic             sel_ok;
    logic [NUM_CH-1:0] full, empty;
    req_w_t           head  [NUM_CH];
    logic [CNT_W-1:0] level [NUM_CH];

    // Only when the select field can encode more than NUM_CH values is a misroute possible.
    if ((1 << CH_W) > NUM_CH) begin : g_sel_chk
        assign sel_ok = int'(in_ch_sel) < NUM_CH;
    end else begin : g_sel_all
        assign sel_ok = 1'b1;
    end

    assign in_tr_rdy = !sel_ok || !full[in_ch_sel];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic push;
        assign push = in_tr_vld && sel_ok && in_ch_sel == CH_W'(k);
        aux_req_fifo #(.DEPTH(DEPTH), .T(req_w_t)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push),
            .wdata ({in_cmd, in_data & {DATA_W{CH_DATA_EN[k]}}, in_address, in_len}),
            .pop   (out_tr_rdy[k]),
            .rdata (head[k]),
            .full  (full[k]),
            .empty (empty[k]),
            .level (level[k])
        );
        assign out_tr_vld[k]                     = !empty[k];
        assign out_cmd[k*CMD_W +: CMD_W]         = empty[k] ? '0 : head[k].cmd;
        assign out_data[k*DATA_W +: DATA_W]      = (empty[k] || !CH_DATA_EN[k]) ? '0 : head[k].data;
        assign out_address[k*ADDR_W +: ADDR_W]   = empty[k] ? '0 : head[k].address;
        assign out_len[k*LEN_W +: LEN_W]         = empty[k] ? '0 : head[k].len;
        assign ch_level[k*CNT_W +: CNT_W]        = level[k];
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) route_err <= 1'b0;
        else     route_err <= in_tr_vld && !sel_ok;

endmodule

// File: tb/tb_aux_req_router.sv
// tb_aux_req_router: checks a 2-channel and a 3-channel router against a
// queue-based model every cycle, plus directed literal expectations.
module tb_aux_req_router;
    import aux_router_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 0;
    logic        rst = 0;
    logic [1:0]  cmd;
    logic [7:0]  data;
    logic [19:0] addr;
    logic [7:0]  len;
    logic        vld  [2];
    logic [1:0]  sel  [2];
    logic [2:0]  ordy [2];

    logic [3:0]  c2;  logic [15:0] d2; logic [39:0] a2; logic [15:0] l2;
    logic [1:0]  v2;  logic [3:0]  lv2; logic rdy2, err2;
    logic [5:0]  c3;  logic [23:0] d3; logic [59:0] a3; logic [23:0] l3;
    logic [2:0]  v3;  logic [5:0]  lv3; logic rdy3, err3;

    req_t        o_r   [2][3];
    logic [1:0]  o_lv  [2][3];
    logic [2:0]  o_v   [2];
    logic        o_rdy [2];
    logic        o_err [2];

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    aux_req_router #(.NUM_CH(2), .DEPTH(DEPTH)) u2 (
        .clk(clk), .rst(rst), .in_cmd(cmd), .in_data(data), .in_address(addr), .in_len(len),
        .in_ch_sel(sel[0][0]), .in_tr_vld(vld[0]), .in_tr_rdy(rdy2),
        .out_cmd(c2), .out_data(d2), .out_address(a2), .out_len(l2),
        .out_tr_vld(v2), .out_tr_rdy(ordy[0][1:0]), .ch_level(lv2), .route_err(err2)
    );

    aux_req_router #(.NUM_CH(3), .DEPTH(DEPTH)) u3 (
        .clk(clk), .rst(rst), .in_cmd(cmd), .in_data(data), .in_address(addr), .in_len(len),
        .in_ch_sel(sel[1]), .in_tr_vld(vld[1]), .in_tr_rdy(rdy3),
        .out_cmd(c3), .out_data(d3), .out_address(a3), .out_len(l3),
        .out_tr_vld(v3), .out_tr_rdy(ordy[1]), .ch_level(lv3), .route_err(err3)
    );

    for (genvar k = 0; k < 2; k++) begin : g_o2
        assign o_r[0][k]  = {c2[k*2 +: 2], d2[k*8 +: 8], a2[k*20 +: 20], l2[k*8 +: 8]};
        assign o_lv[0][k] = lv2[k*2 +: 2];
    end
    assign o_r[0][2]  = '0;
    assign o_lv[0][2] = '0;
    for (genvar k = 0; k < 3; k++) begin : g_o3
        assign o_r[1][k]  = {c3[k*2 +: 2], d3[k*8 +: 8], a3[k*20 +: 20], l3[k*8 +: 8]};
        assign o_lv[1][k] = lv3[k*2 +: 2];
    end
    assign o_v[0]   = {1'b0, v2};
    assign o_v[1]   = v3;
    assign o_rdy[0] = rdy2;
    assign o_rdy[1] = rdy3;
    assign o_err[0] = err2;
    assign o_err[1] = err3;

    // Model: one queue per channel; only channel 0 keeps its data field.
    req_t mq [2][3][$];
    bit   merr [2] = '{0, 0};

    always @(posedge clk or posedge rst) begin : mdl
        int  n;
        bit  acc;
        req_t r;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 3; k++) mq[d][k].delete();
                merr[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                n = d ? 3 : 2;
                acc = vld[d] && (sel[d] >= n || mq[d][sel[d]].size() < DEPTH);
                merr[d] = vld[d] && sel[d] >= n;
                for (int k = 0; k < n; k++)
                    if (mq[d][k].size() > 0 && ordy[d][k]) void'(mq[d][k].pop_front());
                if (acc && sel[d] < n) begin
                    r = '{cmd: cmd, data: (sel[d] == 0) ? data : 8'h00, address: addr, len: len};
                    mq[d][sel[d]].push_back(r);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : cmp
        int n;
        for (int d = 0; d < 2; d++) begin
            n = d ? 3 : 2;
            for (int k = 0; k < n; k++) begin
                check($sformatf("u%0d vld%0d", n, k), 64'(o_v[d][k]), 64'(mq[d][k].size() > 0));
                check($sformatf("u%0d fields%0d", n, k), 64'(o_r[d][k]),
                      64'((mq[d][k].size() > 0) ? mq[d][k][0] : req_t'('0)));
                check($sformatf("u%0d level%0d", n, k), 64'(o_lv[d][k]), 64'(mq[d][k].size()));
            end
            check($sformatf("u%0d in_tr_rdy", n), 64'(o_rdy[d]),
                  64'(sel[d] >= n || mq[d][sel[d]].size() < DEPTH));
            check($sformatf("u%0d route_err", n), 64'(o_err[d]), 64'(merr[d]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic [1:0] s, input logic [1:0] c,
                         input logic [7:0] dt, input logic [19:0] ad, input logic [7:0] ln);
        vld[d] = 1; sel[d] = s; cmd = c; data = dt; addr = ad; len = ln;
    endtask

    initial begin
        vld = '{0, 0}; sel = '{0, 0}; ordy = '{0, 0};
        cmd = 0; data = 0; addr = 0; len = 0;
        #1 rst = 1;
        step(); step();
        rst = 0;
        check("reset vld", 64'(v2), 64'd0);
        check("reset level", 64'(lv2), 64'd0);

        // basic route to channel 0
        drive(0, 0, 2'b01, 8'hA5, 20'h00100, 8'h03);
        step();
        vld[0] = 0;
        check("basic vld", 64'(v2), 64'b01);
        check("basic ch0", 64'(o_r[0][0]), 64'({2'b01, 8'hA5, 20'h00100, 8'h03}));
        check("basic ch1 zero", 64'(o_r[0][1]), 64'd0);

        // channel 1 data is masked
        drive(0, 1, 2'b10, 8'hFF, 20'h12345, 8'h07);
        step();
        vld[0] = 0;
        check("mask ch1", 64'(o_r[0][1]), 64'({2'b10, 8'h00, 20'h12345, 8'h07}));
        ordy[0] = 3'b011;
        step();
        ordy[0] = 0;
        check("drained", 64'(lv2), 64'd0);

        // fill channel 0 under backpressure
        drive(0, 0, 2'b11, 8'h11, 20'h00001, 8'h01);
        step();
        data = 8'h22;
        step();
        data = 8'h33;
        #1;
        check("full rdy sel0", 64'(rdy2), 64'd0);
        check("full level", 64'(lv2[1:0]), 64'd2);
        sel[0] = 1;
        #1;
        check("full rdy sel1", 64'(rdy2), 64'd1);
        vld[0] = 0; sel[0] = 0;
        step();
        check("held while full", 64'(d2[7:0]), 64'h11);
        ordy[0] = 3'b001;
        step();
        check("pop order", 64'(d2[7:0]), 64'h22);
        step();
        check("empty after pops", 64'(v2), 64'd0);

        // push and pop together at level 1
        drive(0, 0, 2'b00, 8'h44, 20'h00002, 8'h02);
        ordy[0] = 0;
        step();
        data = 8'h55;
        ordy[0] = 3'b001;
        step();
        vld[0] = 0;
        check("pushpop level", 64'(lv2[1:0]), 64'd1);
        check("pushpop head", 64'(d2[7:0]), 64'h55);
        step();
        ordy[0] = 0;

        // misroute on the 3-channel router, then a valid route to channel 2
        drive(1, 3, 2'b01, 8'h66, 20'h00003, 8'h04);
        #1;
        check("misroute rdy", 64'(rdy3), 64'd1);
        step();
        vld[1] = 0;
        check("misroute err", 64'(err3), 64'd1);
        check("misroute levels", 64'(lv3), 64'd0);
        step();
        check("misroute err pulse", 64'(err3), 64'd0);
        drive(1, 2, 2'b10, 8'h77, 20'h00004, 8'h05);
        step();
        vld[1] = 0;
        check("ch2 route", 64'(o_r[1][2]), 64'({2'b10, 8'h00, 20'h00004, 8'h05}));
        step();

        // reset with both channels holding requests
        drive(0, 0, 2'b01, 8'h88, 20'h00005, 8'h06);
        step();
        sel[0] = 1;
        step();
        vld[0] = 0;
        check("pre-reset vld", 64'(v2), 64'b11);
        #2 rst = 1;
        #1;
        check("async reset vld", 64'(v2), 64'd0);
        check("async reset data", 64'(d2), 64'd0);
        step();
        rst = 0;
        drive(0, 1, 2'b11, 8'h99, 20'h00006, 8'h07);
        step();
        vld[0] = 0;
        check("post-reset route", 64'(v2), 64'b10);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
